// File: rtl/xintf_wb_mailbox.sv
// xintf_wb_mailbox: DSP-XINTF / Wishbone shared mailbox RAM with torn-free doorbell channels.
// Define XINTF_MAILBOX_IRQ_EN to build the DSP notify interrupt on the top RAM word.
module xintf_wb_mailbox #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH_LOG2     = 11,
    parameter int DSP_ADDR_WIDTH = 15,
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_BASE        = 'h00A,
    parameter int ACK_LATENCY    = 2
) (
    input  logic                               CLK_I,
    input  logic                               RST_I,
    input  logic [DSP_ADDR_WIDTH-1:0]          address,
    input  logic                               nCS,
    input  logic                               nRD,
    input  logic                               nWR,
    inout  wire  [DATA_WIDTH-1:0]              data,
    input  logic                               CYC_I,
    input  logic                               STB_I,
    input  logic                               WE_I,
    input  logic [15:0]                        ADR_I,
    input  logic [DATA_WIDTH-1:0]              DAT_I,
    output logic [DATA_WIDTH-1:0]              DAT_O,
    output logic                               ACK_O,
    output logic                               STALL_O,
    output logic [NUM_CHANNELS-1:0]            ch_update,
    output logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] ch_value,
    output logic                               dsp_irq,
    output logic                               collision
);
    localparam int W = DATA_WIDTH;
    localparam int A = DEPTH_LOG2;
    localparam int L = ACK_LATENCY;
    typedef logic [A-1:0] addr_t;

    logic [W-1:0] mem [2**A];
    logic [1:0] cs_q;
    logic [2:0] wr_q;
    addr_t addr_s0, addr_s1, hold_addr, wb_addr;
    logic [W-1:0] hold_data, rd_word;
    logic commit, accept, wb_we;
    logic [L-1:0] pipe;
    logic [NUM_CHANNELS-1:0] pend;
    logic [W-1:0] shadow [NUM_CHANNELS];
    logic unused;

    // wr_q[2] is the previous synchronised nWR, used for rising-edge detection
    assign commit  = wr_q[1] & ~wr_q[2] & ~cs_q[1];
    assign wb_addr = ADR_I[A-1:0];
    assign accept  = CYC_I & STB_I & ~STALL_O;
    assign wb_we   = accept & WE_I;
    assign STALL_O = |pipe;
    assign ACK_O   = pipe[L-1];
    assign data    = (~nCS & ~nRD) ? rd_word : 'z;
    assign unused  = ^{ADR_I[15:A], address[DSP_ADDR_WIDTH-1:A]};

    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            cs_q      <= '1;
            wr_q      <= '1;
            addr_s0   <= '0;
            addr_s1   <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            cs_q    <= {cs_q[0], nCS};
            wr_q    <= {wr_q[1:0], nWR};
            addr_s0 <= address[A-1:0];
            addr_s1 <= addr_s0;
            if (~cs_q[1] & ~wr_q[1]) begin
                hold_addr <= address[A-1:0];
                hold_data <= data;
            end
        end

    // DSP commit is issued last so it wins a same-address write
    always_ff @(posedge CLK_I) begin
        if (wb_we) mem[wb_addr] <= DAT_I;
        if (commit) mem[hold_addr] <= hold_data;
        rd_word <= mem[addr_s1];
    end

    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            pipe      <= '0;
            DAT_O     <= '0;
            collision <= 1'b0;
        end else begin
            pipe <= L'({pipe, accept});
            if (accept & ~WE_I) DAT_O <= mem[wb_addr];
            if (wb_we & commit & (wb_addr == hold_addr)) collision <= 1'b1;
        end

    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            pend      <= '0;
            ch_update <= '0;
            ch_value  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) shadow[c] <= '0;
        end else begin
            ch_update <= pend;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                pend[c] <= commit && hold_addr == A'(CH_BASE + 2*c + 1);
                if (commit && hold_addr == A'(CH_BASE + 2*c)) shadow[c] <= hold_data;
                if (commit && hold_addr == A'(CH_BASE + 2*c + 1))
                    ch_value[c*2*W +: 2*W] <= {hold_data, shadow[c]};
            end
        end

`ifdef XINTF_MAILBOX_IRQ_EN
    logic [2:0] rd_q;

    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) begin
            rd_q    <= '1;
            dsp_irq <= 1'b0;
        end else begin
            rd_q <= {rd_q[1:0], nRD};
            if (wb_we && wb_addr == '1) dsp_irq <= 1'b1;
            else if (rd_q[1] & ~rd_q[2] & ~cs_q[1] && addr_s1 == '1) dsp_irq <= 1'b0;
        end
`else
    assign dsp_irq = 1'b0;
`endif
endmodule

// File: tb/tb_xintf_wb_mailbox.sv
// tb_xintf_wb_mailbox: scoreboard bench for xintf_wb_mailbox with a queue-based reference model.
`timescale 1ns/1ps
module tb_xintf_wb_mailbox;
    localparam int L = 2;
    localparam int NC = 4;
    localparam int CHB = 'h00A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [14:0] address = '0;
    logic n_cs = 1'b1, n_rd = 1'b1, n_wr = 1'b1;
    tri1 [15:0] data;
    logic [15:0] dsp_dout = '0;
    logic dsp_drive = 1'b0;
    assign data = dsp_drive ? dsp_dout : 'z;
    logic cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [15:0] adr_i = '0, dat_i = '0;
    logic [15:0] dat_o;
    logic ack_o, stall_o, dsp_irq, collision;
    logic [NC-1:0] ch_update;
    logic [NC*32-1:0] ch_value;

    xintf_wb_mailbox dut (
        .CLK_I(clk), .RST_I(rst), .address(address), .nCS(n_cs), .nRD(n_rd), .nWR(n_wr),
        .data(data), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .ADR_I(adr_i), .DAT_I(dat_i),
        .DAT_O(dat_o), .ACK_O(ack_o), .STALL_O(stall_o), .ch_update(ch_update),
        .ch_value(ch_value), .dsp_irq(dsp_irq), .collision(collision)
    );

    typedef struct { bit rd; logic [15:0] d; int acc; } wb_exp_t;
    typedef struct { int ch; logic [31:0] v; int at; } ch_exp_t;

    logic [15:0] mdl_mem [2048];
    logic [15:0] mdl_shadow [NC];
    int written[$];
    wb_exp_t wbq[$];
    ch_exp_t chq[$];
    int cycle = 0;
    int n_vec = 0;
    int n_bad = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got no event, required one", name);
    endfunction

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb(bit we, logic [15:0] adr, logic [15:0] d);
        int a;
        a = int'(adr[10:0]);
        for (int g = 0; g < 20 && stall_o; g++) tick();
        if (stall_o) begin
            fail("wb_stall_release");
            return;
        end
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = d;
        tick();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        if (we) begin
            mdl_mem[a] = d;
            written.push_back(a);
        end
        wbq.push_back('{rd: !we, d: we ? 16'h0 : mdl_mem[a], acc: cycle - 1});
    endtask

    task automatic dsp_write(logic [14:0] adr, logic [15:0] d, bit col = 1'b0, logic [15:0] wd = '0);
        int a, off;
        a = int'(adr[10:0]);
        off = a - CHB;
        address = adr; dsp_dout = d; dsp_drive = 1'b1; n_cs = 1'b0; n_wr = 1'b0;
        tick(4);
        n_wr = 1'b1;
        if (off >= 0 && off < 2*NC) begin
            if (off % 2 == 1) chq.push_back('{ch: off/2, v: {d, mdl_shadow[off/2]}, at: cycle + 4});
            else mdl_shadow[off/2] = d;
        end
        if (col) begin
            tick(2);
            cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'(a); dat_i = wd;
            tick();
            cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
            wbq.push_back('{rd: 1'b0, d: 16'h0, acc: cycle - 1});
            tick();
        end else tick(4);
        n_cs = 1'b1; dsp_drive = 1'b0;
        mdl_mem[a] = d;
        written.push_back(a);
        tick(3);
    endtask

    task automatic dsp_read(logic [14:0] adr, string nm);
        logic [15:0] exp;
        exp = mdl_mem[adr[10:0]];
        address = adr; n_cs = 1'b0; n_rd = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i >= 4) chk(nm, data, exp);
        end
        @(posedge clk);
        #1 n_rd = 1'b1;
        @(negedge clk);
        chk("dsp_rd_hiz", data, 16'hFFFF);
        tick(4);
        n_cs = 1'b1;
        tick(3);
    endtask

    task automatic chk_reset(string p);
        chk({p, "_dat_o"}, dat_o, 0);
        chk({p, "_ack_o"}, ack_o, 0);
        chk({p, "_stall_o"}, stall_o, 0);
        chk({p, "_ch_update"}, ch_update, 0);
        chk({p, "_ch_value"}, |ch_value, 0);
        chk({p, "_dsp_irq"}, dsp_irq, 0);
        chk({p, "_collision"}, collision, 0);
        chk({p, "_data_hiz"}, data, 16'hFFFF);
    endtask

    always @(negedge clk) if (!rst) begin
        if (wbq.size() != 0) chk("stall_busy", stall_o, 1);
        if (ack_o) begin
            if (wbq.size() == 0) fail("ack_unexpected");
            else begin
                wb_exp_t e;
                e = wbq.pop_front();
                chk("ack_latency", 64'(cycle - e.acc), L);
                if (e.rd) chk("wb_read", dat_o, e.d);
            end
        end else if (wbq.size() != 0 && cycle - wbq[0].acc > L + 4) begin
            fail("ack_timeout");
            void'(wbq.pop_front());
        end
        if (ch_update != 0) begin
            if (chq.size() == 0) fail("ch_update_unexpected");
            else begin
                ch_exp_t e;
                e = chq.pop_front();
                chk("ch_update_mask", ch_update, 64'(1 << e.ch));
                chk("ch_update_time", 64'(cycle), 64'(e.at));
                chk("ch_value", ch_value[e.ch*32 +: 32], e.v);
            end
        end else if (chq.size() != 0 && cycle > chq[0].at + 2) begin
            fail("ch_update_timeout");
            void'(chq.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NC; i++) mdl_shadow[i] = '0;
        tick(3);
        chk_reset("rst");
        rst = 1'b0;
        tick(2);

        dsp_write(15'h000A, 16'h1234);
        dsp_write(15'h000B, 16'hABCD);
        chk("ch0_pair", ch_value[31:0], 32'hABCD1234);

        wb(1'b1, 16'h0020, 16'h5A5A);
        wb(1'b0, 16'hF820, 16'h0);

        wb(1'b1, 16'h0030, 16'h0F0F);
        tick(4);
        dsp_read(15'h0030, "dsp_read_030");

        chk("collision_clear", collision, 0);
        dsp_write(15'h0040, 16'h1111, 1'b1, 16'h2222);
        chk("collision_set", collision, 1);
        wb(1'b0, 16'h0040, 16'h0);

        wb(1'b1, 16'h07FF, 16'h0055);
`ifdef XINTF_MAILBOX_IRQ_EN
        chk("irq_set", dsp_irq, 1);
`else
        chk("irq_off", dsp_irq, 0);
`endif
        tick(4);
        dsp_read(15'h47FF, "dsp_read_7ff");
        chk("irq_cleared", dsp_irq, 0);

        for (int n = 0; n < 60; n++) begin
            int op, a;
            logic [15:0] d;
            op = $urandom_range(0, 3);
            d = 16'($urandom_range(0, 16'hFFFE));
            case (op)
                0: wb(1'b1, {5'($urandom), 11'($urandom_range(0, 2046))}, d);
                1: begin
                    a = written[$urandom_range(0, written.size() - 1)];
                    wb(1'b0, {5'($urandom), 11'(a)}, 16'h0);
                end
                2: dsp_write({4'($urandom), 11'(CHB + $urandom_range(0, 2*NC - 1))}, d);
                default: begin
                    tick(4);
                    a = written[$urandom_range(0, written.size() - 1)];
                    dsp_read({4'($urandom), 11'(a)}, "dsp_read_rand");
                end
            endcase
        end
        tick(8);
        chk("wbq_drained", wbq.size(), 0);
        chk("chq_drained", chq.size(), 0);

        for (int g = 0; g < 20 && stall_o; g++) tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 16'h0020;
        tick();
        cyc_i = 1'b0; stb_i = 1'b0;
        rst = 1'b1;
        tick(2);
        chk_reset("abort_in_rst");
        rst = 1'b0;
        wbq.delete();
        chq.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_ack_after_abort", ack_o, 0);
        end
        chk_reset("abort_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/xintf_wb_mailbox.md
# xintf_wb_mailbox

Parametrised DSP-XINTF / Wishbone shared mailbox. It replaces the fixed dual-port RAM plus single divisor-update FSM with one block that has:
- configurable width and depth;
- NUM_CHANNELS doorbell channels that hand over torn-free two-word values;
- a pipelined Wishbone slave port with stall and ack latency;
- an optional DSP notify interrupt.

It sits between the DSP external bus pins and the internal shared Wishbone bus as slave 0.

## Interface
Parameters:
- DATA_WIDTH, 16: word width of both ports.
- DEPTH_LOG2, 11: RAM holds 2^DEPTH_LOG2 words. DSP and Wishbone use the low DEPTH_LOG2 address bits.
- DSP_ADDR_WIDTH, 15: width of the DSP address pins.
- NUM_CHANNELS, 4: number of doorbell channels, 1..8.
- CH_BASE, 'h00A: word address of channel 0. Channel c owns CH_BASE+2c (low word) and CH_BASE+2c+1 (high word).
- ACK_LATENCY, 2: cycles from accepted STB_I to ACK_O, range 1..4.

Ports:
- CLK_I  in  1  single system clock.
- RST_I  in  1  asynchronous, active-high reset.
- address  in  DSP_ADDR_WIDTH  DSP address, asynchronous to CLK_I.
- nCS, nRD, nWR  in  1 each  DSP strobes, active low, asynchronous.
- data  inout  DATA_WIDTH  DSP data bus.
- CYC_I, STB_I, WE_I  in  1 each  Wishbone cycle, strobe and write enable.
- ADR_I  in  16  Wishbone word address.
- DAT_I  in  DATA_WIDTH  Wishbone write data.
- DAT_O  out  DATA_WIDTH  Wishbone read data.
- ACK_O  out  1  Wishbone acknowledge.
- STALL_O  out  1  Wishbone stall.
- ch_update  out  NUM_CHANNELS  one-cycle pulse per channel on a new value.
- ch_value  out  NUM_CHANNELS*2*DATA_WIDTH  latched {high,low} pair per channel, channel 0 in the LSBs.
- dsp_irq  out  1  notify interrupt to the DSP.
- collision  out  1  sticky flag; set on a same-address, same-cycle write from both ports.

## Operation
- DSP input synchronisation:
  - nCS, nRD and nWR pass through 2-flop synchronisers.
  - address and data are sampled every cycle in which synchronised nCS=0 and nWR=0. The last sample is held.
- DSP write commit:
  - Occurs on the rising edge of synchronised nWR while synchronised nCS=0.
  - The held data is written to the RAM at the held address, in one cycle.
- DSP read:
  - The RAM is read every cycle at the synchronised address into a registered read word.
  - data is driven with the read word when the raw pins show nCS=0 and nRD=0. Otherwise data is high-Z.
- Doorbell channels:
  - A DSP commit to a channel's low word only loads a shadow register.
  - A DSP commit to a channel's high word latches {high, shadow} into ch_value[c] and pulses ch_update[c] on the next cycle.
  - ch_value therefore never shows a half-updated pair.
  - Wishbone writes to channel words update the RAM only. They affect neither ch_value nor ch_update.
- Wishbone slave:
  - Accepts one access when CYC_I & STB_I & ~STALL_O.
  - STALL_O=1 from acceptance until ACK_O has been issued. One access is outstanding at most.
  - ACK_O is a one-cycle pulse ACK_LATENCY cycles after acceptance. DAT_O is valid in the ACK cycle.
  - Writes happen in the acceptance cycle.
  - ADR_I bits above DEPTH_LOG2 are ignored.
  - If CYC_I drops before ACK_O, the ACK still fires. A write already performed is not undone.
- Collision: when the DSP commit and a Wishbone write target the same address in the same cycle, the DSP data is stored, the Wishbone access is still ACKed, and collision is set until reset.
- Reset:
  - RST_I asserted mid-transfer aborts any pending ACK without emitting it.
  - It clears the synchronisers, shadows, ch_value, ch_update, dsp_irq, collision, ACK_O and STALL_O, and sets DAT_O to 0.
  - RAM contents are undefined after reset.

## Timing
- Reset values: DAT_O=0, ACK_O=0, STALL_O=0, ch_update=0, ch_value=0, dsp_irq=0, collision=0, data high-Z.
- DSP write: the RAM is updated 3 CLK_I cycles after the nWR rising edge at the pin. ch_update follows 1 cycle later, 4 cycles total.
- DSP read: data is valid 4 CLK_I cycles after address is stable. DSP read wait states must cover at least 4 CLK_I periods plus pad delay.
- Wishbone throughput: one access per ACK_LATENCY+1 cycles.
- Simultaneous commits to the high words of two channels are impossible, since the DSP performs one write per commit. Back-to-back commits to the same channel each produce their own pulse.

## Configuration
- XINTF_MAILBOX_IRQ_EN defined:
  - A Wishbone write to the top word (2^DEPTH_LOG2-1) sets dsp_irq one cycle after acceptance.
  - dsp_irq clears on the DSP read of that word, detected on the synchronised nRD rising edge.
  - If a set and a clear occur in the same cycle, the set wins.
- XINTF_MAILBOX_IRQ_EN undefined: dsp_irq is tied to 0 and no irq logic is built.

## Test plan
- DSP writes 'h1234 to 'h00A, then 'hABCD to 'h00B. Required:
  - ch_update[0] pulses once, 4 cycles after the second nWR rise.
  - ch_value[31:0]='hABCD1234.
  - No pulse after the first write.
- Wishbone writes 'h5A5A to 'h020, then reads 'h020 with ACK_LATENCY=2. Required:
  - ACK_O 2 cycles after each acceptance.
  - STALL_O high in between.
  - Read returns DAT_O='h5A5A.
- Wishbone writes 'h0F0F to 'h030; DSP then reads 'h030 with a 6-cycle strobe. Required: data='h0F0F from cycle 4. data is high-Z whenever nRD=1.
- DSP and Wishbone write 'h1111 and 'h2222 to 'h040 in the same cycle. Required: the RAM holds 'h1111, ACK_O is issued, and collision=1.
- With XINTF_MAILBOX_IRQ_EN, Wishbone writes 'h7FF. Required: dsp_irq=1 after 1 cycle, and cleared after the DSP read of 'h7FF completes.
- RST_I is asserted 1 cycle after a Wishbone acceptance. Required: no ACK_O, and all outputs at their reset values.
